tlb_nway_plru: RTL and testbench

Parametrised set-associative TLB and the successor of the fixed 8-way/8-set TLB. Way count, set count, address, page and PCID widths are all generic, and it uses a generic tree-PLRU. Adds real valid bits, an invalid-first fill policy, duplicate-free insertion, a ready/valid request handshake, and a sequenced flush engine (all / by PCID / by VA+PCID). Sits between the core's address-generation stage and the page-table walker, which performs inserts on miss.

---
 rtl/tlb_pkg.sv | 28 ++
 rtl/tlb_plru_tree.sv | 38 +++
 rtl/tlb_nway_plru.sv | 208 ++++++++++++++++++++
 tb/tb_tlb_nway_plru.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared encodings and width helpers for the parametrised TLB and its PLRU tree.
package tlb_pkg;

  typedef enum logic [1:0] {
    FLUSH_ALL     = 2'd0,
    FLUSH_PCID    = 2'd1,
    FLUSH_VA_PCID = 2'd2,
    FLUSH_RSVD    = 2'd3
  } flush_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic int set_w(input int nset);
    return $clog2(nset);
  endfunction

  function automatic int tag_w(input int saddr, input int spage, input int nset);
    return saddr - spage - $clog2(nset);
  endfunction

  function automatic int ppn_w(input int saddr, input int spage);
    return saddr - spage;
  endfunction

endpackage

// File: rtl/tlb_plru_tree.sv
// Combinational tree-PLRU helper: touch update and victim search for one set.
module tlb_plru_tree #(
  parameter int NWAY = 8
) (
  input  logic [NWAY-2:0]         bits,
  input  logic [$clog2(NWAY)-1:0] touch_way,
  output logic [NWAY-2:0]         bits_new,
  output logic [$clog2(NWAY)-1:0] victim
);
  localparam int LW = $clog2(NWAY);

  logic [LW-1:0] v_node;
  logic [LW-1:0] t_node;
  logic          dir;

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    v_node = '0;
    victim = '0;
    for (int l = 0; l < LW; l++) begin
      victim[LW-1-l] = bits[v_node];
      v_node = LW'(2 * v_node + 1 + {{(LW-1){1'b0}}, bits[v_node]});
    end
  end

  // Each node on the touched path is pointed at the opposite subtree.
  always_comb begin
    t_node   = '0;
    dir      = 1'b0;
    bits_new = bits;
    for (int l = 0; l < LW; l++) begin
      dir              = touch_way[LW-1-l];
      bits_new[t_node] = ~dir;
      t_node           = LW'(2 * t_node + 1 + {{(LW-1){1'b0}}, dir});
    end
  end

endmodule

// File: rtl/tlb_nway_plru.sv
// Set-associative TLB with tree-PLRU, duplicate-free insert and sequenced flush engine.
// Optional hit/miss counters are enabled by defining TLB_STATS_EN.
module tlb_nway_plru
  import tlb_pkg::*;
#(
  parameter int SADDR = 64,
  parameter int SPAGE = 12,
  parameter int NSET  = 8,
  parameter int NWAY  = 8,
  parameter int SPCID = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SADDR-1:0] req_va,
  input  logic [SPCID-1:0] req_pcid,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [SADDR-1:0] resp_ta,
  input  logic             ins_valid,
  input  logic [SADDR-1:0] ins_va,
  input  logic [SADDR-1:0] ins_pa,
  input  logic [SPCID-1:0] ins_pcid,
  input  logic             flush_valid,
  input  logic [1:0]       flush_mode,
  input  logic [SADDR-1:0] flush_va,
  input  logic [SPCID-1:0] flush_pcid,
  output logic             busy
`ifdef TLB_STATS_EN
  ,
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses
`endif
);
  localparam int SW = set_w(NSET);
  localparam int TW = tag_w(SADDR, SPAGE, NSET);
  localparam int PW = ppn_w(SADDR, SPAGE);
  localparam int LW = $clog2(NWAY);

  logic [NWAY-1:0]  valid_q [NSET];
  logic [NWAY-2:0]  plru_q  [NSET];
  logic [TW-1:0]    tag_q   [NSET][NWAY];
  logic [SPCID-1:0] pcid_q  [NSET][NWAY];
  logic [PW-1:0]    ppn_q   [NSET][NWAY];

  state_e           state_q, state_d;
  logic [SW-1:0]    fl_cnt_q;
  flush_mode_e      fl_mode_q;
  logic [SW-1:0]    fl_set_q;
  logic [TW-1:0]    fl_tag_q;
  logic [SPCID-1:0] fl_pcid_q;
  logic [NWAY-1:0]  fl_clr;
  logic             fl_start;

  logic          req_fire, lk_hit;
  logic [SW-1:0] lk_set;
  logic [TW-1:0] lk_tag;
  logic [LW-1:0] lk_way, lk_victim_unused;
  logic [NWAY-2:0] lk_bits_new;

  logic          ins_fire, ins_dup, ins_free;
  logic [SW-1:0] ins_set;
  logic [TW-1:0] ins_tag;
  logic [LW-1:0] dup_way, free_way, ins_victim, ins_way;
  logic [NWAY-2:0] ins_bits_base, ins_bits_new;

  logic unused_bits;
  assign unused_bits = ^{ins_va[SPAGE-1:0], ins_pa[SPAGE-1:0], flush_va[SPAGE-1:0]};

  assign busy      = (state_q == ST_FLUSH);
  assign req_ready = !rst && (state_q == ST_IDLE) && !flush_valid;
  assign req_fire  = req_valid && req_ready;
  assign ins_fire  = ins_valid && !rst && (state_q == ST_IDLE);
  assign fl_start  = flush_valid && (state_q == ST_IDLE);

  assign lk_set  = req_va[SPAGE +: SW];
  assign lk_tag  = req_va[SPAGE+SW +: TW];
  assign ins_set = ins_va[SPAGE +: SW];
  assign ins_tag = ins_va[SPAGE+SW +: TW];

  // Descending scans leave the lowest matching / free way selected.
  always_comb begin
    lk_hit   = 1'b0;
    lk_way   = '0;
    ins_dup  = 1'b0;
    dup_way  = '0;
    ins_free = 1'b0;
    free_way = '0;
    for (int w = NWAY - 1; w >= 0; w--) begin
      if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag && pcid_q[lk_set][w] == req_pcid) begin
        lk_hit = 1'b1;
        lk_way = LW'(w);
      end
      if (valid_q[ins_set][w] && tag_q[ins_set][w] == ins_tag && pcid_q[ins_set][w] == ins_pcid) begin
        ins_dup = 1'b1;
        dup_way = LW'(w);
      end
      if (!valid_q[ins_set][w]) begin
        ins_free = 1'b1;
        free_way = LW'(w);
      end
    end
    ins_way = ins_dup ? dup_way : (ins_free ? free_way : ins_victim);
  end

  // A same-set lookup hit is touched first so the insert touch lands on top of it.
  assign ins_bits_base = (req_fire && lk_hit && lk_set == ins_set) ? lk_bits_new : plru_q[ins_set];

  tlb_plru_tree #(.NWAY(NWAY)) u_lk_plru (
    .bits      (plru_q[lk_set]),
    .touch_way (lk_way),
    .bits_new  (lk_bits_new),
    .victim    (lk_victim_unused)
  );

  tlb_plru_tree #(.NWAY(NWAY)) u_ins_plru (
    .bits      (ins_bits_base),
    .touch_way (ins_way),
    .bits_new  (ins_bits_new),
    .victim    (ins_victim)
  );

  always_comb begin
    fl_clr = '0;
    for (int w = 0; w < NWAY; w++) begin
      case (fl_mode_q)
        FLUSH_PCID:    fl_clr[w] = (pcid_q[fl_cnt_q][w] == fl_pcid_q);
        FLUSH_VA_PCID: fl_clr[w] = (fl_cnt_q == fl_set_q) && (pcid_q[fl_cnt_q][w] == fl_pcid_q)
                                   && (tag_q[fl_cnt_q][w] == fl_tag_q);
        default:       fl_clr[w] = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush_valid) state_d = ST_FLUSH;
      ST_FLUSH: if (fl_cnt_q == SW'(NSET - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fl_cnt_q   <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_ta    <= '0;
    end else begin
      state_q    <= state_d;
      fl_cnt_q   <= (state_q == ST_FLUSH) ? fl_cnt_q + 1'b1 : '0;
      resp_valid <= req_fire;
      if (req_fire) begin
        resp_hit <= lk_hit;
        if (lk_hit) resp_ta <= {ppn_q[lk_set][lk_way], req_va[SPAGE-1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSET; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (state_q == ST_FLUSH) valid_q[fl_cnt_q] <= valid_q[fl_cnt_q] & ~fl_clr;
      else if (ins_fire)       valid_q[ins_set][ins_way] <= 1'b1;
      if (req_fire && lk_hit && !(ins_fire && lk_set == ins_set)) plru_q[lk_set] <= lk_bits_new;
      if (ins_fire) plru_q[ins_set] <= ins_bits_new;
    end
  end

  // NOTE: entry payload and flush operands carry no reset; the cleared valid bits gate them.
  always_ff @(posedge clk) begin
    if (ins_fire) begin
      tag_q[ins_set][ins_way]  <= ins_tag;
      pcid_q[ins_set][ins_way] <= ins_pcid;
      ppn_q[ins_set][ins_way]  <= ins_pa[SADDR-1:SPAGE];
    end
    if (fl_start) begin
      fl_mode_q <= flush_mode_e'(flush_mode);
      fl_set_q  <= flush_va[SPAGE +: SW];
      fl_tag_q  <= flush_va[SPAGE+SW +: TW];
      fl_pcid_q <= flush_pcid;
    end
  end

`ifdef TLB_STATS_EN
  logic clr_stats;
  assign clr_stats = fl_start && (flush_mode == FLUSH_ALL || flush_mode == FLUSH_RSVD);

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (req_fire) begin
      if (lk_hit && stat_hits != '1)          stat_hits   <= stat_hits + 1'b1;
      else if (!lk_hit && stat_misses != '1)  stat_misses <= stat_misses + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tlb_nway_plru.sv
// Directed self-checking bench for tlb_nway_plru (default 8-set / 8-way configuration).
module tb_tlb_nway_plru;
  import tlb_pkg::*;

  localparam int NSET = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [63:0] req_va;
  logic [11:0] req_pcid;
  logic        resp_valid, resp_hit;
  logic [63:0] resp_ta;
  logic        ins_valid;
  logic [63:0] ins_va, ins_pa;
  logic [11:0] ins_pcid;
  logic        flush_valid;
  logic [1:0]  flush_mode;
  logic [63:0] flush_va;
  logic [11:0] flush_pcid;
  logic        busy;
`ifdef TLB_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int order [7] = '{6, 4, 5, 0, 1, 2, 3};

  always #5 clk = ~clk;

  tlb_nway_plru dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_va      (req_va),
    .req_pcid    (req_pcid),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_ta     (resp_ta),
    .ins_valid   (ins_valid),
    .ins_va      (ins_va),
    .ins_pa      (ins_pa),
    .ins_pcid    (ins_pcid),
    .flush_valid (flush_valid),
    .flush_mode  (flush_mode),
    .flush_va    (flush_va),
    .flush_pcid  (flush_pcid),
    .busy        (busy)
`ifdef TLB_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [63:0] va, input logic [63:0] pa, input logic [11:0] pcid);
    ins_valid = 1'b1; ins_va = va; ins_pa = pa; ins_pcid = pcid;
    tick();
    ins_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [63:0] va, input logic [11:0] pcid,
                        input logic exp_hit, input logic [63:0] exp_ta);
    req_valid = 1'b1; req_va = va; req_pcid = pcid;
    tick();
    req_valid = 1'b0;
    check({tag, ".valid"}, resp_valid, 1);
    check({tag, ".hit"}, resp_hit, exp_hit);
    if (exp_hit) check({tag, ".ta"}, resp_ta, exp_ta);
  endtask

  task automatic flush(input logic [1:0] mode, input logic [63:0] va, input logic [11:0] pcid);
    flush_valid = 1'b1; flush_mode = mode; flush_va = va; flush_pcid = pcid;
    tick();
    flush_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check(tag, n, NSET);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_va = '0; req_pcid = '0;
    ins_valid = 1'b0; ins_va = '0; ins_pa = '0; ins_pcid = '0;
    flush_valid = 1'b0; flush_mode = '0; flush_va = '0; flush_pcid = '0;

    // Reset state
    tick();
    check("rst.resp_valid", resp_valid, 0);
    check("rst.resp_hit", resp_hit, 0);
    check("rst.resp_ta", resp_ta, 0);
    check("rst.busy", busy, 0);
    check("rst.req_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst.req_ready", req_ready, 1);

    // Basic hit / PCID miss, resp_ta holds on miss, resp_valid is a pulse
    insert(64'h1000, 64'h8_8000, 12'd5);
    lookup("basic", 64'h1ABC, 12'd5, 1'b1, 64'h8_8ABC);
    lookup("pcid_miss", 64'h1ABC, 12'd6, 1'b0, 64'h0);
    check("pcid_miss.ta_hold", resp_ta, 64'h8_8ABC);
    tick();
    check("idle.resp_valid", resp_valid, 0);

    // Lookup and insert to the same set in one cycle: lookup sees old contents
    req_valid = 1'b1; req_va = 64'h6123; req_pcid = 12'd2;
    ins_valid = 1'b1; ins_va = 64'h6000; ins_pa = 64'h7_7000; ins_pcid = 12'd2;
    tick();
    req_valid = 1'b0; ins_valid = 1'b0;
    check("same_cycle.valid", resp_valid, 1);
    check("same_cycle.hit", resp_hit, 0);
    lookup("same_cycle.after", 64'h6123, 12'd2, 1'b1, 64'h7_7123);

    // Duplicate insert overwrites in place; set 2 then still holds 8 distinct entries
    insert(64'h2000, 64'h1_1000, 12'd7);
    insert(64'h2000, 64'h2_2000, 12'd7);
    lookup("dup", 64'h2010, 12'd7, 1'b1, 64'h2_2010);
    for (int k = 1; k < 8; k++)
      insert((64'(k) << 15) | 64'h2000, 64'(12'h200 + k) << 12, 12'd7);
    lookup("dup.fill0", 64'h2010, 12'd7, 1'b1, 64'h2_2010);
    for (int k = 1; k < 8; k++)
      lookup($sformatf("dup.fill%0d", k), (64'(k) << 15) | 64'h2000, 12'd7, 1'b1,
             64'(12'h200 + k) << 12);

    // Tree-PLRU: fill set 0, touch 6,4,5,0,1,2,3 so the tree points at way 7
    for (int k = 0; k < 8; k++)
      insert(64'(k) << 15, 64'(12'h100 + k) << 12, 12'd1);
    for (int i = 0; i < 7; i++)
      lookup($sformatf("plru.touch%0d", order[i]), 64'(order[i]) << 15, 12'd1, 1'b1,
             64'(12'h100 + order[i]) << 12);
    insert(64'd8 << 15, 64'h108 << 12, 12'd1);
    lookup("plru.evicted7", 64'd7 << 15, 12'd1, 1'b0, 64'h0);
    for (int k = 0; k < 7; k++)
      lookup($sformatf("plru.kept%0d", k), 64'(k) << 15, 12'd1, 1'b1, 64'(12'h100 + k) << 12);
    lookup("plru.new8", 64'd8 << 15, 12'd1, 1'b1, 64'h108 << 12);

    // Flush by PCID with a request and an insert held during the flush
    insert(64'h3000, 64'h3_3000, 12'd3);
    insert(64'h4000, 64'h4_4000, 12'd4);
    flush_valid = 1'b1; flush_mode = 2'd1; flush_va = '0; flush_pcid = 12'd3;
    req_valid = 1'b1; req_va = 64'h4000; req_pcid = 12'd4;
    #1;
    check("flush_start.req_ready", req_ready, 0);
    tick();
    flush_valid = 1'b0;
    ins_valid = 1'b1; ins_va = 64'h5000; ins_pa = 64'h5_5000; ins_pcid = 12'd9;
    check("flush.busy", busy, 1);
    check("flush.req_ready", req_ready, 0);
    check("flush.resp_valid", resp_valid, 0);
    wait_idle("flush1.cycles");
    check("flush1.end.resp_valid", resp_valid, 0);
    req_valid = 1'b0; ins_valid = 1'b0;
    lookup("flush1.pcid3", 64'h3000, 12'd3, 1'b0, 64'h0);
    lookup("flush1.pcid4", 64'h4000, 12'd4, 1'b1, 64'h4_4000);
    lookup("flush1.dropped_ins", 64'h5000, 12'd9, 1'b0, 64'h0);
    lookup("flush1.pcid5", 64'h1ABC, 12'd5, 1'b1, 64'h8_8ABC);

    // Flush by VA page + PCID
    insert(64'h1000, 64'h6_6000, 12'd6);
    flush(2'd2, 64'h1000, 12'd5);
    wait_idle("flush2.cycles");
    lookup("flush2.target", 64'h1000, 12'd5, 1'b0, 64'h0);
    lookup("flush2.other_pcid", 64'h1000, 12'd6, 1'b1, 64'h6_6000);
    lookup("flush2.other_page", 64'h4000, 12'd4, 1'b1, 64'h4_4000);
    lookup("flush2.set0", 64'h0, 12'd1, 1'b1, 64'h10_0000);

    // Flush all
    flush(2'd0, 64'h0, 12'd0);
    wait_idle("flush0.cycles");
    lookup("flush0.a", 64'h4000, 12'd4, 1'b0, 64'h0);
    lookup("flush0.b", 64'h1000, 12'd6, 1'b0, 64'h0);
    lookup("flush0.c", 64'h0, 12'd1, 1'b0, 64'h0);
    lookup("flush0.d", 64'h2010, 12'd7, 1'b0, 64'h0);

    // Reset in the third cycle of a flush
    insert(64'h4000, 64'h4_4000, 12'd4);
    insert(64'h7000, 64'h9_9000, 12'd7);
    flush(2'd1, 64'h0, 12'hABC);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid.busy", busy, 0);
    check("rst_mid.resp_valid", resp_valid, 0);
    tick();
    check("rst_mid.busy_after", busy, 0);
    lookup("rst_mid.a", 64'h4000, 12'd4, 1'b0, 64'h0);
    lookup("rst_mid.b", 64'h7000, 12'd7, 1'b0, 64'h0);

    // Five hits after the two misses above
    insert(64'h4000, 64'h4_4000, 12'd4);
    for (int i = 0; i < 5; i++)
      lookup($sformatf("stats.hit%0d", i), 64'h4000 + 64'(i), 12'd4, 1'b1, 64'h4_4000 + 64'(i));
`ifdef TLB_STATS_EN
    check("stats.hits", stat_hits, 5);
    check("stats.misses", stat_misses, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    cyc = 0;
    while (cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    $display("FAIL watchdog: observed %0d cycles expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
